// File: rtl/ov7670_dvp_tx_if.sv
// Pixel stream into the DVP transmitter: RGB565 words with a
// start-of-frame marker, moved by a valid/ready handshake.
interface ov7670_dvp_tx_if;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_ready;

    // Pixel producer side
    modport master (
        output pix_valid,
        output pix_data,
        output pix_sof,
        input  pix_ready
    );

    // Transmitter side
    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_sof,
        output pix_ready
    );
endinterface

// File: rtl/ov7670_dvp_tx.sv
// OV7670-style DVP transmitter. Generates vsync/href/d frame timing and
// serialises RGB565 pixels MSB byte first. Pixels are pulled one at a time
// into a single holding register; an empty register at an MSB slot sends FILL
// and flags underrun. All outputs are registered from the next-cycle position,
// so they line up exactly with the timing state they describe.
module ov7670_dvp_tx #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_BLANK     = 144,
    parameter int          V_ACTIVE    = 480,
    parameter int          VSYNC_LINES = 3,
    parameter int          V_BACK      = 17,
    parameter int          V_FRONT     = 10,
    parameter logic [15:0] FILL        = 16'h0000
) (
    input  logic                  pclk,
    input  logic                  resetn,
    input  logic                  en,
    ov7670_dvp_tx_if.slave        pix,
    output logic                  vsync,
    output logic                  href,
    output logic [7:0]            d,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  underrun,
    output logic                  busy
);
    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HCW      = $clog2(LINE_LEN + 1);
    localparam int VCW      = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBACK  = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_VFRONT = 3'd4;

    // Number of lines spent in each frame phase.
    function automatic int lines_of(input logic [2:0] s);
        case (s)
            ST_VSYNC:  return VSYNC_LINES;
            ST_VBACK:  return V_BACK;
            ST_ACTIVE: return V_ACTIVE;
            ST_VFRONT: return V_FRONT;
            default:   return 0;
        endcase
    endfunction

    // Phase that follows s; the end of the front porch is where en decides
    // between another frame and going idle.
    function automatic logic [2:0] succ(input logic [2:0] s, input logic run);
        case (s)
            ST_VSYNC:  return ST_VBACK;
            ST_VBACK:  return ST_ACTIVE;
            ST_ACTIVE: return ST_VFRONT;
            ST_VFRONT: return run ? ST_VSYNC : ST_IDLE;
            default:   return ST_IDLE;
        endcase
    endfunction

    // Walk past any phase configured with zero lines.
    function automatic logic [2:0] enter(input logic [2:0] s, input logic run);
        logic [2:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t != ST_IDLE && lines_of(t) == 0) begin
                t = succ(t, run);
            end
        end
        return t;
    endfunction

    logic [2:0]     state_reg, state_next;
    logic [HCW-1:0] hcnt_reg, hcnt_next;
    logic [VCW-1:0] vcnt_reg, vcnt_next;

    logic           full_reg, full_next;
    logic [15:0]    hold_data_reg;
    logic           hold_sof_reg;
    logic [15:0]    latch_reg, latch_next;

    logic           act_next;
    logic           msb_slot;
    logic           consume;
    logic           discard;
    logic           load;
    logic [15:0]    slot_pix;
    logic [7:0]     d_next;

    assign pix.pix_ready = !full_reg;

    // Frame/line position for the next cycle.
    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        vcnt_next  = vcnt_reg;
        if (state_reg == ST_IDLE) begin
            if (en) begin
                state_next = enter(ST_VSYNC, 1'b1);
                hcnt_next  = '0;
                vcnt_next  = '0;
            end
        end else if (int'(hcnt_reg) == LINE_LEN - 1) begin
            hcnt_next = '0;
            if (int'(vcnt_reg) == lines_of(state_reg) - 1) begin
                vcnt_next  = '0;
                state_next = enter(succ(state_reg, en), en);
            end else begin
                vcnt_next = vcnt_reg + VCW'(1);
            end
        end else begin
            hcnt_next = hcnt_reg + HCW'(1);
        end
    end

    // Byte slot decode, holding-register bookkeeping and next data byte.
    always_comb begin
        act_next   = (state_next == ST_ACTIVE) && (int'(hcnt_next) < 2 * H_ACTIVE);
        msb_slot   = act_next && !hcnt_next[0];
        consume    = msb_slot && full_reg;
        // Stray mid-frame pixels between frames are flushed so the source can
        // resynchronise on the next sof; the ACTIVE entry edge consumes instead.
        discard    = full_reg && !hold_sof_reg && (state_reg != ST_ACTIVE) && !consume;
        load       = pix.pix_valid && !full_reg;
        slot_pix   = full_reg ? hold_data_reg : FILL;
        latch_next = msb_slot ? slot_pix : latch_reg;
        if (!act_next) begin
            d_next = 8'h00;
        end else if (msb_slot) begin
            d_next = slot_pix[15:8];
        end else begin
            d_next = latch_reg[7:0];
        end
        full_next = load || (full_reg && !consume && !discard);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            full_reg      <= 1'b0;
            hold_data_reg <= 16'h0000;
            hold_sof_reg  <= 1'b0;
            latch_reg     <= 16'h0000;
            vsync         <= 1'b0;
            href          <= 1'b0;
            d             <= 8'h00;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            underrun      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hcnt_reg    <= hcnt_next;
            vcnt_reg    <= vcnt_next;
            full_reg    <= full_next;
            latch_reg   <= latch_next;
            if (load) begin
                hold_data_reg <= pix.pix_data;
                hold_sof_reg  <= pix.pix_sof;
            end
            vsync       <= (state_next == ST_VSYNC);
            href        <= act_next;
            d           <= d_next;
            frame_end   <= (state_next == ST_VSYNC) && !vsync;
            frame_start <= (state_next != ST_VSYNC) && vsync;
            underrun    <= msb_slot && !full_reg;
            busy        <= (state_next != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_ov7670_dvp_tx.sv
// Bench for ov7670_dvp_tx in a small configuration (10-cycle lines, 50-cycle
// frames). Expected outputs come from frame-position arithmetic and the list
// of pixels the bench intends each frame to carry.
module tb_ov7670_dvp_tx;
    localparam int HA = 4;
    localparam int HB = 2;
    localparam int VA = 2;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = 2 * HA + HB;
    localparam int P  = (VS + VB + VA + VF) * L;
    localparam int NPIX = HA * VA;
    localparam logic [15:0] FILL = 16'h0000;

    logic       pclk = 1'b0;
    logic       resetn;
    logic       en;
    logic       vsync, href, frame_start, frame_end, underrun, busy;
    logic [7:0] d;

    ov7670_dvp_tx_if pix_bus ();

    ov7670_dvp_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF), .FILL(FILL)
    ) dut (
        .pclk(pclk), .resetn(resetn), .en(en), .pix(pix_bus),
        .vsync(vsync), .href(href), .d(d),
        .frame_start(frame_start), .frame_end(frame_end),
        .underrun(underrun), .busy(busy)
    );

    always #5 pclk = ~pclk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: frame position and the pixels each frame should carry.
    bit          run = 0;
    int          c = 0;
    logic [15:0] cur_w [NPIX];
    int          cur_n = 0;
    bit          cur_junk = 0;
    int          junk_left = 0;
    int          src_i = 0;
    logic [15:0] nxt_w [NPIX];
    int          nxt_n = 0;
    bit          nxt_junk = 0;
    int          href_cnt = 0;
    int          frame_no = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0t c=%0d observed=%h expected=%h", tag, $time, c, obs, exp);
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < NPIX; i++) cur_w[i] = nxt_w[i];
        cur_n     = nxt_n;
        cur_junk  = nxt_junk;
        junk_left = nxt_junk ? 3 : 0;
        src_i     = 0;
        frame_no++;
    endtask

    task automatic set_random_frame();
        for (int i = 0; i < NPIX; i++) nxt_w[i] = 16'($urandom);
        nxt_n    = NPIX;
        nxt_junk = 0;
    endtask

    // Compare every output against the model for the current cycle.
    task automatic check_outputs();
        int ln, h, p;
        logic [15:0] w;
        logic e_vs, e_hr, e_fs, e_fe, e_ur, e_busy;
        logic [7:0] e_d;
        bit act_line;
        e_vs = 0; e_hr = 0; e_fs = 0; e_fe = 0; e_ur = 0; e_busy = 0; e_d = 8'h00;
        ln = c / L;
        h  = c % L;
        act_line = run && (ln >= VS + VB) && (ln < VS + VB + VA);
        if (run) begin
            e_busy = 1;
            e_vs   = (c < VS * L);
            e_fe   = (c == 0);
            e_fs   = (c == VS * L);
            if (act_line && h < 2 * HA) begin
                e_hr = 1;
                p    = (ln - VS - VB) * HA + h / 2;
                w    = (p < cur_n) ? cur_w[p] : FILL;
                e_d  = (h % 2 == 1) ? w[7:0] : w[15:8];
                e_ur = (h % 2 == 0) && (p >= cur_n);
            end
        end
        chk("vsync", 8'(vsync), 8'(e_vs));
        chk("href", 8'(href), 8'(e_hr));
        chk("d", d, e_d);
        chk("frame_start", 8'(frame_start), 8'(e_fs));
        chk("frame_end", 8'(frame_end), 8'(e_fe));
        chk("underrun", 8'(underrun), 8'(e_ur));
        chk("busy", 8'(busy), 8'(e_busy));
        if (h == 0) href_cnt = 0;
        if (href === 1'b1) href_cnt++;
        if (act_line && h == L - 1) chk("href_width", 8'(href_cnt), 8'(2 * HA));
    endtask

    // Present the next pixel (or a stray one) for the coming edge.
    task automatic drive_inputs();
        bit offer, is_junk, accepted;
        offer = 0; is_junk = 0;
        pix_bus.pix_data = 16'($urandom);
        pix_bus.pix_sof  = 1'b0;
        if (run && c >= VS * L) begin
            if (junk_left > 0) begin
                offer = 1; is_junk = 1;
            end else if (src_i < cur_n) begin
                offer = 1;
                pix_bus.pix_data = cur_w[src_i];
                pix_bus.pix_sof  = (src_i == 0);
            end
        end
        pix_bus.pix_valid = offer && (cur_junk || c >= (VS + VB) * L - 5 || $urandom_range(1, 0) == 1);
        accepted = pix_bus.pix_valid && (pix_bus.pix_ready === 1'b1);
        if (accepted) begin
            if (is_junk) junk_left--;
            else src_i++;
        end
    endtask

    // What the coming edge does to the frame position.
    task automatic advance_model();
        if (!resetn) begin
            run = 0;
        end else if (!run) begin
            if (en) begin run = 1; c = 0; load_frame(); end
        end else begin
            c++;
            if (c == P) begin
                if (en) begin c = 0; load_frame(); end
                else run = 0;
            end
        end
    endtask

    task automatic step();
        drive_inputs();
        advance_model();
        @(negedge pclk);
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vsync"}, 8'(vsync), 8'h00);
        chk({tag, "_href"}, 8'(href), 8'h00);
        chk({tag, "_d"}, d, 8'h00);
        chk({tag, "_fs"}, 8'(frame_start), 8'h00);
        chk({tag, "_fe"}, 8'(frame_end), 8'h00);
        chk({tag, "_ur"}, 8'(underrun), 8'h00);
        chk({tag, "_busy"}, 8'(busy), 8'h00);
        chk({tag, "_ready"}, 8'(pix_bus.pix_ready), 8'h01);
    endtask

    initial begin
        logic [15:0] dir_w [NPIX];
        dir_w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                  16'h1357, 16'h2468, 16'h369C, 16'h48BD};
        resetn = 1'b0;
        en     = 1'b0;
        pix_bus.pix_valid = 1'b0;
        pix_bus.pix_data  = 16'h0000;
        pix_bus.pix_sof   = 1'b0;
        repeat (3) @(negedge pclk);
        check_all_zero("reset");

        // Directed frame with gapless pixels
        for (int i = 0; i < NPIX; i++) nxt_w[i] = dir_w[i];
        nxt_n = NPIX; nxt_junk = 0;
        resetn = 1'b1;
        en     = 1'b1;
        repeat (P) step();
        $display("frame %0d: directed pixels, %0d assertions so far", frame_no, n_assert);

        // No pixels at all: FILL and underrun on every MSB slot
        nxt_n = 0; nxt_junk = 0;
        repeat (P) step();
        $display("frame %0d: starved, %0d assertions so far", frame_no, n_assert);

        // Stray pixels ahead of the sof pixel
        set_random_frame();
        nxt_w[0] = 16'hABCD;
        nxt_junk = 1;
        repeat (P) step();
        $display("frame %0d: resync after strays, %0d assertions so far", frame_no, n_assert);

        // Random pixel data with random gaps
        for (int f = 0; f < 2; f++) begin
            set_random_frame();
            repeat (P) step();
            $display("frame %0d: random loopback, %0d assertions so far", frame_no, n_assert);
        end

        // en dropped in the first active line: frame completes, then idle
        set_random_frame();
        repeat (VS * L + VB * L + 2) step();
        en = 1'b0;
        repeat (P - (VS * L + VB * L + 2)) step();
        repeat (6) step();
        $display("frame %0d: en dropped, idle afterwards, %0d assertions so far", frame_no, n_assert);

        // Restart, then reset asynchronously in the middle of an active line
        en = 1'b1;
        set_random_frame();
        repeat (VS * L + VB * L + 3) step();
        pix_bus.pix_valid = 1'b0;
        #2 resetn = 1'b0;
        #1 check_all_zero("async_reset");
        run = 0;
        @(negedge pclk);
        resetn = 1'b1;
        set_random_frame();
        repeat (P) step();
        $display("frame %0d: restart after reset, %0d assertions so far", frame_no, n_assert);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
